buffer_mux_controller: RTL and testbench
========================================

// Module: buffer_mux_controller
// PURPOSE
//  Link-select sequencer for the buffer mux. It chooses which of four downstream
//  link buffers receives the next data word, and drives the buffer mux select.
//  Single-width words use one link; multi-width words use an even-aligned pair of links.
//  The pointer stalls while the downstream buffer reports full, and the stall is
//  reported upstream as registered back-pressure.
// PARAMETERS
//  DATA_WIDTH  40  width of one link slot in bits; carried for the mux datapath, unused in control logic
// PORTS
//  clk          in   1  single clock; all state updates on the rising edge
//  rst          in   1  asynchronous reset, active-high
//  in_full      in   1  downstream buffer of the current link is full (stall request)
//  multi_width  in   1  current word is double width and occupies a link pair
//  out_full     out  1  registered back-pressure to the upstream source
//  link_num     out  2  currently selected link (0..3); drives the mux select
// BEHAVIOUR
//  - Reset:
//    - rst=1 asynchronously forces link_num=0 and out_full=0, with no clock needed.
//    - Both outputs hold while rst=1.
//    - On the first rising edge after rst falls, normal operation applies.
//  - Both outputs are registers with no combinational path from inputs to outputs.
//    Latency is one clock.
//  - Per rising edge, evaluated in priority order:
//    1. in_full=1: link_num holds; out_full<=1. This applies regardless of multi_width.
//    2. in_full=0 and multi_width=0: link_num<=link_num+1, modulo 4 (3 -> 0); out_full<=0.
//    3. in_full=0 and multi_width=1: link_num<={~link_num[1],1'b0}, i.e. jump to the next even pair base.
//       Mapping: 0->2, 1->2, 2->0, 3->0. An odd pointer is realigned, and the skipped link is not used.
//       out_full<=0.
//  - out_full is the in_full value sampled at the previous edge. It deasserts one cycle after in_full drops.
//  - Mode changes: multi_width may toggle on any cycle. The next-state rule uses the value
//    sampled at the edge, with no extra bubble or flush.
//  - State space is link_num only (4 states, a free-running ring). There are no illegal states.
//  - Inputs are X-free after reset.
// TESTING
//  1. Reset values:
//     - Stimulus: assert rst with clk idle.
//     - Required: link_num=0 and out_full=0 immediately.
//  2. Single-width wrap:
//     - Stimulus: rst then release; in_full=0, multi_width=0.
//     - Required: one edge gives link_num=1; four more edges step through 2, 3, 0, 1.
//  3. Multi-width alignment:
//     - Stimulus: start at link_num=1, then set multi_width=1.
//     - Required: successive edges give link_num=2, then 0, then 2.
//     - Stimulus: starting from 3 instead.
//     - Required: the first edge gives 0.
//  4. Stall:
//     - Stimulus: at link_num=2, set in_full=1 for 3 edges.
//     - Required: link_num stays 2 and out_full=1 after the first edge.
//     - Stimulus: drop in_full.
//     - Required: the next edge gives link_num=3 and out_full=0.
//  5. Mixed sequence, reset to 0:
//     - Stimulus: one single edge, then one multi edge, then one single edge.
//     - Required: link_num goes 1, 2, 3.
//  6. Asynchronous reset mid-operation:
//     - Stimulus: at link_num=3 with out_full=1, pulse rst between clock edges.
//     - Required: both outputs clear immediately, and counting resumes from 0.

Source files
------------

// File: rtl/buffer_mux_controller.sv
// buffer_mux_controller: link-select sequencer driving the buffer mux select
module buffer_mux_controller #(
   parameter int DATA_WIDTH = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_full,
   input  logic       multi_width,
   output logic       out_full,
   output logic [1:0] link_num
);
   if (DATA_WIDTH < 1) begin : g_bad_width
      $error("DATA_WIDTH must be positive");
   end
   // advance the link pointer unless stalled; back-pressure is in_full delayed one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_num <= 2'd0;
         out_full <= 1'b0;
      end else begin
         out_full <= in_full;
         link_num <= in_full ? link_num : multi_width ? {~link_num[1], 1'b0} : link_num + 2'd1;
      end
   end
endmodule

// File: tb/tb_buffer_mux_controller.sv
// tb_buffer_mux_controller: scoreboard bench against a ring-of-links reference model
module tb_buffer_mux_controller;
   typedef struct {
      logic [1:0] link;
      logic       full;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_full = 1'b0;
   logic       multi_width = 1'b0;
   logic       out_full;
   logic [1:0] link_num;
   int         checks = 0;
   int         errors = 0;
   int         ml = 0;
   bit         mf = 1'b0;
   exp_t       q[$];

   buffer_mux_controller #(.DATA_WIDTH(40)) dut (
      .clk(clk),
      .rst(rst),
      .in_full(in_full),
      .multi_width(multi_width),
      .out_full(out_full),
      .link_num(link_num)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // one word: set inputs on the falling edge and queue what the next rising edge must show
   task automatic step(input bit f, input bit m);
      @(negedge clk);
      in_full = f;
      multi_width = m;
      if (!f) ml = m ? ((ml / 2 + 1) % 2) * 2 : (ml + 1) % 4;
      mf = f;
      q.push_back('{link: 2'(ml), full: mf});
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain queue_left %0d expected 0", q.size());
         q.delete();
      end
   endtask

   // reset asserted between edges, held across one edge, released between edges
   task automatic do_reset();
      drain();
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_full = 1'b0;
      multi_width = 1'b0;
      #1;
      chk("rst_link_async", link_num, 0);
      chk("rst_full_async", out_full, 0);
      @(posedge clk);
      #1;
      chk("rst_link_hold", link_num, 0);
      chk("rst_full_hold", out_full, 0);
      #1;
      rst = 1'b0;
      ml = 0;
      mf = 1'b0;
   endtask

   // monitor: every rising edge presents a new output pair
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("link_num", link_num, e.link);
         chk("out_full", out_full, e.full);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      repeat (5) step(0, 0);
      do_reset();
      step(0, 0);
      repeat (3) step(0, 1);
      step(0, 0);
      step(0, 1);
      step(0, 0);
      step(0, 0);
      repeat (3) step(1, 1'($urandom_range(0, 1)));
      step(0, 0);
      do_reset();
      step(0, 0);
      step(0, 1);
      step(0, 0);
      step(1, 0);
      drain();
      chk("pre_mid_link", link_num, 3);
      chk("pre_mid_full", out_full, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_link", link_num, 0);
      chk("mid_rst_full", out_full, 0);
      #1;
      rst = 1'b0;
      ml = 0;
      mf = 1'b0;
      repeat (3) step(0, 0);
      for (int i = 0; i < 400; i++) step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
